sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares one dual-port packet SRAM (1 write port, 1 read port) between NUM_REQ write requesters and NUM_REQ read requesters.
- Independent round-robin arbiters for the write side and the read side.
- Drives the SRAM command pins directly.
- Returns read data to the winning requester one cycle later, tagged by a one-hot valid.
- Sits between the port ingress/egress engines and the SRAM instance.

Parameters:
NUM_REQ, 4, number of write requesters and number of read requesters (2..8)
ADDR_WIDTH, 14, SRAM address width
DATA_WIDTH, 16, SRAM word width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
wr_req  in  NUM_REQ  write request per requester; held until granted
wr_addr  in  NUM_REQ*ADDR_WIDTH  packed write addresses; requester i at slice i
wr_data  in  NUM_REQ*DATA_WIDTH  packed write data
wr_gnt  out  NUM_REQ  one-hot write grant; combinational, same cycle
rd_req  in  NUM_REQ  read request per requester; held until granted
rd_addr  in  NUM_REQ*ADDR_WIDTH  packed read addresses
rd_gnt  out  NUM_REQ  one-hot read grant; combinational, same cycle
rd_vld  out  NUM_REQ  one-hot read-data valid; registered
rd_data  out  DATA_WIDTH  read data for the requester flagged in rd_vld
sram_wr_en  out  1  SRAM write enable
sram_wr_addr  out  ADDR_WIDTH  SRAM write address
sram_din  out  DATA_WIDTH  SRAM write data
sram_rd_en  out  1  SRAM read enable
sram_rd_addr  out  ADDR_WIDTH  SRAM read address
sram_dout  in  DATA_WIDTH  SRAM read data, valid the cycle after sram_rd_en

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_ptr = 0, rd_ptr = 0, rd_vld = 0, fwd_flag = 0, fwd_data = 0, rd_tag = 0.
  - wr_gnt, rd_gnt, sram_wr_en and sram_rd_en forced 0 while rst_n is low.
- Write arbitration, combinational:
  - Search wr_req from index wr_ptr upward, wrapping modulo NUM_REQ.
  - The first set bit wins: wr_gnt one-hot; sram_wr_en = |wr_req.
  - sram_wr_addr and sram_din are muxed from the winner's slice. When there is no request, both outputs are 0.
  - On the clock edge with a grant, wr_ptr <= (winner+1) mod NUM_REQ. With no grant, wr_ptr holds.
- Read arbitration: identical scheme with rd_ptr, rd_gnt, sram_rd_en, sram_rd_addr.
- Read return, 1-cycle latency:
  - On the cycle after a read grant to i: rd_vld = one-hot(i), rd_data = sram_dout.
  - Otherwise rd_vld = 0 and rd_data holds its last value.
  - Back-to-back grants give rd_vld every cycle.
- Same-cycle collision:
  - Trigger: sram_wr_en and sram_rd_en both high, with sram_wr_addr == sram_rd_addr.
  - Register fwd_flag = 1 and fwd_data = sram_din.
  - Next cycle, rd_data = fwd_data instead of sram_dout, so the read returns the newly written word.
  - With no collision, fwd_flag = 0.
- Requester contract: req stays high until the gnt cycle. req may drop in the same cycle as gnt. Address and data must be stable while req is high.
- Fairness: a continuously requesting requester is granted within NUM_REQ cycles.
- Reset mid-operation:
  - An in-flight read produces no rd_vld.
  - Pointers restart at 0 after release.
  - SRAM contents are untouched by this block.
- Non-power-of-two NUM_REQ: pointer wrap uses an explicit compare to NUM_REQ-1, not bit truncation.

Test Plan:
- Reset, then write addr 0x0010 data 0xBEEF from requester 2; next cycle read 0x0010 from requester 1 -> wr_gnt=0100 in the write cycle; rd_gnt=0010 in the read cycle; rd_vld=0010 and rd_data=0xBEEF one cycle after the read grant.
- All four wr_req held high for 8 cycles from reset -> wr_gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000.
- wr_ptr=0, wr_req=1010 for 4 cycles -> grants 0010,1000,0010,1000.
- Same cycle: requester 0 writes 0x0A5A to addr 0x3FFF, requester 3 reads 0x3FFF (prior content 0x1111) -> next cycle rd_vld=1000, rd_data=0x0A5A.
- Read granted, then rst_n pulsed low mid-cycle before the next edge -> rd_vld stays 0, grants immediately 0; after release the first grant goes to the lowest-index requester.
- Reads back-to-back to 0x0001,0x0002,0x0003 from requester 1, preloaded 0x0101,0x0202,0x0303 -> rd_vld=0010 for 3 consecutive cycles with rd_data 0x0101,0x0202,0x0303.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Shares a 1W/1R packet SRAM between NUM_REQ writers and NUM_REQ readers using
// independent round-robin arbiters, with one-cycle read return and write-to-read forwarding.
module sram_port_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 14,
   parameter int DATA_WIDTH = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            wr_req,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] wr_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data,
   output logic [NUM_REQ-1:0]            wr_gnt,
   input  logic [NUM_REQ-1:0]            rd_req,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr,
   output logic [NUM_REQ-1:0]            rd_gnt,
   output logic [NUM_REQ-1:0]            rd_vld,
   output logic [DATA_WIDTH-1:0]         rd_data,
   output logic                          sram_wr_en,
   output logic [ADDR_WIDTH-1:0]         sram_wr_addr,
   output logic [DATA_WIDTH-1:0]         sram_din,
   output logic                          sram_rd_en,
   output logic [ADDR_WIDTH-1:0]         sram_rd_addr,
   input  logic [DATA_WIDTH-1:0]         sram_dout
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef logic [PTR_W-1:0] ptr_t;

   typedef struct packed {
      logic found;
      ptr_t idx;
   } pick_t;

   // First set bit at or after ptr, wrapping; the wrap is an explicit compare so
   // non-power-of-two requester counts never index past NUM_REQ-1.
   function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req, input ptr_t ptr);
      pick_t res;
      int    pos;
      ptr_t  sel;
      res = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         pos = int'(ptr) + k;
         if (pos >= NUM_REQ) pos = pos - NUM_REQ;
         sel = ptr_t'(pos);
         if (!res.found && req[sel]) begin
            res.found = 1'b1;
            res.idx   = sel;
         end
      end
      return res;
   endfunction

   function automatic ptr_t next_ptr(input ptr_t win);
      return (win == ptr_t'(NUM_REQ - 1)) ? '0 : win + ptr_t'(1);
   endfunction

   function automatic logic [NUM_REQ-1:0] onehot(input ptr_t i);
      return {{(NUM_REQ-1){1'b0}}, 1'b1} << i;
   endfunction

   logic [ADDR_WIDTH-1:0] wr_addr_a [NUM_REQ];
   logic [DATA_WIDTH-1:0] wr_data_a [NUM_REQ];
   logic [ADDR_WIDTH-1:0] rd_addr_a [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign wr_addr_a[g] = wr_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign wr_data_a[g] = wr_data[g*DATA_WIDTH +: DATA_WIDTH];
      assign rd_addr_a[g] = rd_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
   end

   ptr_t                  wr_ptr_q, wr_ptr_d;
   ptr_t                  rd_ptr_q, rd_ptr_d;
   logic                  rd_pend_q, rd_pend_d;
   ptr_t                  rd_tag_q, rd_tag_d;
   logic                  fwd_flag_q, fwd_flag_d;
   logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;
   logic [DATA_WIDTH-1:0] rd_hold_q, rd_hold_d;

   pick_t                 wr_pick, rd_pick;
   logic                  collision;
   logic [DATA_WIDTH-1:0] ret_data;

   assign wr_pick = rr_pick(wr_req, wr_ptr_q);
   assign rd_pick = rr_pick(rd_req, rd_ptr_q);

   // Grants and enables are qualified by rst_n so nothing reaches the SRAM during reset.
   assign wr_gnt       = (rst_n && wr_pick.found) ? onehot(wr_pick.idx) : '0;
   assign sram_wr_en   = rst_n & wr_pick.found;
   assign sram_wr_addr = wr_pick.found ? wr_addr_a[wr_pick.idx] : '0;
   assign sram_din     = wr_pick.found ? wr_data_a[wr_pick.idx] : '0;

   assign rd_gnt       = (rst_n && rd_pick.found) ? onehot(rd_pick.idx) : '0;
   assign sram_rd_en   = rst_n & rd_pick.found;
   assign sram_rd_addr = rd_pick.found ? rd_addr_a[rd_pick.idx] : '0;

   assign collision = sram_wr_en && sram_rd_en && (sram_wr_addr == sram_rd_addr);

   // The SRAM returns the old word on a same-address collision, so substitute the new one.
   assign ret_data = fwd_flag_q ? fwd_data_q : sram_dout;
   assign rd_data  = rd_pend_q ? ret_data : rd_hold_q;
   assign rd_vld   = rd_pend_q ? onehot(rd_tag_q) : '0;

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path infers a latch.
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      rd_pend_d  = rd_pick.found;
      rd_tag_d   = rd_tag_q;
      fwd_flag_d = collision;
      fwd_data_d = fwd_data_q;
      rd_hold_d  = rd_hold_q;
      if (wr_pick.found) wr_ptr_d = next_ptr(wr_pick.idx);
      if (rd_pick.found) begin
         rd_ptr_d = next_ptr(rd_pick.idx);
         rd_tag_d = rd_pick.idx;
      end
      if (collision) fwd_data_d = sram_din;
      if (rd_pend_q) rd_hold_d = ret_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         rd_pend_q  <= 1'b0;
         rd_tag_q   <= '0;
         fwd_flag_q <= 1'b0;
         fwd_data_q <= '0;
         rd_hold_q  <= '0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values of the others.
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         rd_pend_q  <= rd_pend_d;
         rd_tag_q   <= rd_tag_d;
         fwd_flag_q <= fwd_flag_d;
         fwd_data_q <= fwd_data_d;
         rd_hold_q  <= rd_hold_d;
      end
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios plus a randomized run against a
// behavioural model of the arbiters, the SRAM contents and the read return.
module tb_sram_port_arbiter;

   localparam int N  = 4;
   localparam int AW = 14;
   localparam int DW = 16;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    wr_req, rd_req;
   logic [N*AW-1:0] wr_addr, rd_addr;
   logic [N*DW-1:0] wr_data;
   logic [N-1:0]    wr_gnt, rd_gnt, rd_vld;
   logic [DW-1:0]   rd_data;
   logic            sram_wr_en, sram_rd_en;
   logic [AW-1:0]   sram_wr_addr, sram_rd_addr;
   logic [DW-1:0]   sram_din, sram_dout;

   logic            pl_en;
   logic [AW-1:0]   pl_addr;
   logic [DW-1:0]   pl_data;
   logic [DW-1:0]   mem [0:(1<<AW)-1];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sram_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
      .rd_vld(rd_vld), .rd_data(rd_data),
      .sram_wr_en(sram_wr_en), .sram_wr_addr(sram_wr_addr), .sram_din(sram_din),
      .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr), .sram_dout(sram_dout)
   );

   // SRAM model: read-before-write, data out one cycle after the read enable.
   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      if (sram_wr_en) mem[sram_wr_addr] <= sram_din;
      if (sram_rd_en) sram_dout <= mem[sram_rd_addr];
   end

   // Reference state for the randomized run.
   logic [DW-1:0] ref_mem [0:15];
   int            m_wr_ptr, m_rd_ptr;
   logic [N-1:0]  exp_vld;
   logic [DW-1:0] exp_data, exp_hold;
   bit            hold_ok;
   int            wait_w [N];
   int            wait_r [N];

   function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
      for (int k = 0; k < N; k++)
         if (req[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n   = 1'b0;
      wr_req  = '0;
      rd_req  = '0;
      wr_addr = '0;
      rd_addr = '0;
      wr_data = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n    = 1'b1;
      m_wr_ptr = 0;
      m_rd_ptr = 0;
      exp_vld  = '0;
      hold_ok  = 1'b0;
      for (int i = 0; i < N; i++) begin
         wait_w[i] = 0;
         wait_r[i] = 0;
      end
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
      pl_en   = 1'b1;
      pl_addr = a;
      pl_data = d;
      step();
      pl_en = 1'b0;
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      wr_req = '1;
      rd_req = '1;
      @(negedge clk);
      checks++;
      if ({wr_gnt, rd_gnt, sram_wr_en, sram_rd_en, rd_vld} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: wr_gnt=%b rd_gnt=%b wr_en=%b rd_en=%b rd_vld=%b, all must be 0",
                  wr_gnt, rd_gnt, sram_wr_en, sram_rd_en, rd_vld);
      end
   endtask

   task automatic test_write_read();
      apply_reset();
      wr_req = 4'b0100;
      wr_addr[2*AW +: AW] = 14'h0010;
      wr_data[2*DW +: DW] = 16'hBEEF;
      @(negedge clk);
      checks++;
      if ({wr_gnt, sram_wr_en, sram_wr_addr, sram_din} !== {4'b0100, 1'b1, 14'h0010, 16'hBEEF}) begin
         errors++;
         $display("FAIL wr_cmd: gnt=%b en=%b addr=%h din=%h, want 0100 1 0010 beef",
                  wr_gnt, sram_wr_en, sram_wr_addr, sram_din);
      end
      step();
      wr_req = '0;
      rd_req = 4'b0010;
      rd_addr[1*AW +: AW] = 14'h0010;
      @(negedge clk);
      checks++;
      if ({rd_gnt, sram_rd_en, sram_rd_addr, sram_wr_en} !== {4'b0010, 1'b1, 14'h0010, 1'b0}) begin
         errors++;
         $display("FAIL rd_cmd: gnt=%b en=%b addr=%h wr_en=%b, want 0010 1 0010 0",
                  rd_gnt, sram_rd_en, sram_rd_addr, sram_wr_en);
      end
      step();
      rd_req = '0;
      @(negedge clk);
      checks++;
      if ({rd_vld, rd_data} !== {4'b0010, 16'hBEEF}) begin
         errors++;
         $display("FAIL rd_return: vld=%b data=%h, want 0010 beef", rd_vld, rd_data);
      end
      step();
      @(negedge clk);
      checks++;
      if ({rd_vld, rd_data} !== {4'b0000, 16'hBEEF}) begin
         errors++;
         $display("FAIL rd_hold: vld=%b data=%h, want 0000 beef", rd_vld, rd_data);
      end
   endtask

   task automatic test_rr_all();
      logic [N-1:0] e;
      apply_reset();
      wr_req = 4'b1111;
      for (int c = 0; c < 8; c++) begin
         e = 4'b0001 << (c % N);
         @(negedge clk);
         checks++;
         if (wr_gnt !== e) begin
            errors++;
            $display("FAIL rr_all[%0d]: wr_gnt=%b want %b", c, wr_gnt, e);
         end
         step();
      end
      wr_req = '0;
   endtask

   task automatic test_rr_sparse();
      logic [N-1:0] e;
      apply_reset();
      wr_req = 4'b1010;
      for (int c = 0; c < 4; c++) begin
         e = (c % 2 == 0) ? 4'b0010 : 4'b1000;
         @(negedge clk);
         checks++;
         if (wr_gnt !== e) begin
            errors++;
            $display("FAIL rr_sparse[%0d]: wr_gnt=%b want %b", c, wr_gnt, e);
         end
         step();
      end
      wr_req = '0;
   endtask

   task automatic test_collision();
      apply_reset();
      preload(14'h3FFF, 16'h1111);
      wr_req = 4'b0001;
      wr_addr[0 +: AW] = 14'h3FFF;
      wr_data[0 +: DW] = 16'h0A5A;
      rd_req = 4'b1000;
      rd_addr[3*AW +: AW] = 14'h3FFF;
      @(negedge clk);
      checks++;
      if ({wr_gnt, rd_gnt} !== {4'b0001, 4'b1000}) begin
         errors++;
         $display("FAIL coll_gnt: wr_gnt=%b rd_gnt=%b, want 0001 1000", wr_gnt, rd_gnt);
      end
      step();
      wr_req = '0;
      rd_req = '0;
      @(negedge clk);
      checks++;
      if ({rd_vld, rd_data} !== {4'b1000, 16'h0A5A}) begin
         errors++;
         $display("FAIL coll_fwd: vld=%b data=%h, want 1000 0a5a", rd_vld, rd_data);
      end
      step();
      rd_req = 4'b1000;
      step();
      rd_req = '0;
      @(negedge clk);
      checks++;
      if ({rd_vld, rd_data} !== {4'b1000, 16'h0A5A}) begin
         errors++;
         $display("FAIL coll_reread: vld=%b data=%h, want 1000 0a5a", rd_vld, rd_data);
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] e;
      apply_reset();
      preload(14'h0001, 16'h0101);
      preload(14'h0002, 16'h0202);
      preload(14'h0003, 16'h0303);
      rd_req = 4'b0010;
      for (int c = 0; c < 4; c++) begin
         if (c < 3) rd_addr[1*AW +: AW] = AW'(c + 1);
         else rd_req = '0;
         @(negedge clk);
         if (c < 3) begin
            checks++;
            if (rd_gnt !== 4'b0010) begin
               errors++;
               $display("FAIL b2b_gnt[%0d]: rd_gnt=%b want 0010", c, rd_gnt);
            end
         end
         if (c > 0) begin
            e = {2{8'(c)}};
            checks++;
            if ({rd_vld, rd_data} !== {4'b0010, e}) begin
               errors++;
               $display("FAIL b2b_ret[%0d]: vld=%b data=%h, want 0010 %h", c, rd_vld, rd_data, e);
            end
         end
         step();
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      rd_req = 4'b0010;
      step();
      rd_req = 4'b0100;
      @(negedge clk);
      checks++;
      if (rd_gnt !== 4'b0100) begin
         errors++;
         $display("FAIL mid_pre_gnt: rd_gnt=%b want 0100", rd_gnt);
      end
      step();
      rd_req = '0;
      #2;
      rst_n  = 1'b0;
      rd_req = 4'b0101;
      #1;
      checks++;
      if ({rd_vld, rd_gnt, sram_rd_en} !== '0) begin
         errors++;
         $display("FAIL mid_in_reset: rd_vld=%b rd_gnt=%b rd_en=%b, all must be 0",
                  rd_vld, rd_gnt, sram_rd_en);
      end
      #2;
      rst_n = 1'b1;
      #1;
      checks++;
      if ({rd_gnt, rd_vld} !== {4'b0001, 4'b0000}) begin
         errors++;
         $display("FAIL mid_restart: rd_gnt=%b rd_vld=%b, want 0001 0000", rd_gnt, rd_vld);
      end
      step();
      rd_req = '0;
      @(negedge clk);
      checks++;
      if (rd_vld !== 4'b0001) begin
         errors++;
         $display("FAIL mid_first_ret: rd_vld=%b want 0001", rd_vld);
      end
   endtask

   task automatic test_random();
      int            w, r;
      logic [N-1:0]  ew, er;
      logic [AW-1:0] waddr, raddr;
      logic [DW-1:0] wdat, edata;
      apply_reset();
      for (int a = 0; a < 16; a++) begin
         ref_mem[a] = DW'($urandom);
         preload(AW'(a), ref_mem[a]);
      end
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (!wr_req[i] && $urandom_range(0, 2) == 0) begin
               wr_req[i] = 1'b1;
               wr_addr[i*AW +: AW] = AW'($urandom_range(0, 15));
               wr_data[i*DW +: DW] = DW'($urandom);
            end
            if (!rd_req[i] && $urandom_range(0, 2) == 0) begin
               rd_req[i] = 1'b1;
               rd_addr[i*AW +: AW] = AW'($urandom_range(0, 15));
            end
         end
         @(negedge clk);
         w     = rr_pick(wr_req, m_wr_ptr);
         r     = rr_pick(rd_req, m_rd_ptr);
         ew    = (w < 0) ? '0 : (4'b0001 << w);
         er    = (r < 0) ? '0 : (4'b0001 << r);
         waddr = (w < 0) ? '0 : wr_addr[w*AW +: AW];
         wdat  = (w < 0) ? '0 : wr_data[w*DW +: DW];
         raddr = (r < 0) ? '0 : rd_addr[r*AW +: AW];
         checks++;
         if ({wr_gnt, sram_wr_en, sram_wr_addr, sram_din} !== {ew, (w >= 0), waddr, wdat}) begin
            errors++;
            $display("FAIL rnd_wr[%0d]: gnt=%b en=%b addr=%h din=%h, want %b %b %h %h",
                     cyc, wr_gnt, sram_wr_en, sram_wr_addr, sram_din, ew, (w >= 0), waddr, wdat);
         end
         checks++;
         if ({rd_gnt, sram_rd_en, sram_rd_addr} !== {er, (r >= 0), raddr}) begin
            errors++;
            $display("FAIL rnd_rd[%0d]: gnt=%b en=%b addr=%h, want %b %b %h",
                     cyc, rd_gnt, sram_rd_en, sram_rd_addr, er, (r >= 0), raddr);
         end
         if (exp_vld != '0 || hold_ok) begin
            edata = (exp_vld != '0) ? exp_data : exp_hold;
            checks++;
            if ({rd_vld, rd_data} !== {exp_vld, edata}) begin
               errors++;
               $display("FAIL rnd_ret[%0d]: vld=%b data=%h, want %b %h", cyc, rd_vld, rd_data, exp_vld, edata);
            end
         end else begin
            checks++;
            if (rd_vld !== '0) begin
               errors++;
               $display("FAIL rnd_idle[%0d]: vld=%b want 0000", cyc, rd_vld);
            end
         end
         for (int i = 0; i < N; i++) begin
            wait_w[i] = (wr_req[i] && !wr_gnt[i]) ? wait_w[i] + 1 : 0;
            wait_r[i] = (rd_req[i] && !rd_gnt[i]) ? wait_r[i] + 1 : 0;
            if (wr_req[i] || rd_req[i]) begin
               checks++;
               if (wait_w[i] >= N || wait_r[i] >= N) begin
                  errors++;
                  $display("FAIL rnd_fair[%0d] req %0d: waited wr=%0d rd=%0d cycles, limit %0d",
                           cyc, i, wait_w[i], wait_r[i], N - 1);
               end
            end
         end
         if (exp_vld != '0) begin
            exp_hold = exp_data;
            hold_ok  = 1'b1;
         end
         exp_vld = er;
         if (r >= 0) exp_data = (w >= 0 && waddr == raddr) ? wdat : ref_mem[raddr[3:0]];
         if (w >= 0) begin
            ref_mem[waddr[3:0]] = wdat;
            m_wr_ptr = (w + 1) % N;
         end
         if (r >= 0) m_rd_ptr = (r + 1) % N;
         step();
         wr_req = wr_req & ~ew;
         rd_req = rd_req & ~er;
      end
      wr_req = '0;
      rd_req = '0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      pl_en   = 1'b0;
      pl_addr = '0;
      pl_data = '0;
      wr_addr = '0;
      rd_addr = '0;
      wr_data = '0;
      test_reset();
      test_write_read();
      test_rr_all();
      test_rr_sparse();
      test_collision();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
